// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl
// ---------------------------------------------------------------------------
// Loop controller sitting directly in front of the ADPLL's DCO. It filters the
// early/late votes from the bang-bang phase detector, steps a tuning index,
// drives the DCO tuning word and enable, sequences start-up and flags lock.
//
// Optional feature (macro DCO_TUNE_CTRL_THERM_EN):
//   defined     -> o_lambda is thermometer coded (bits 0..idx set)
//   not defined -> o_lambda is one-hot (only bit idx set)
//   Index, lock and all timing are identical in both builds.
//
// Ports:
//   i_clk     reference clock, all logic on its rising edge
//   i_rst     synchronous active-high reset
//   i_en      loop enable
//   i_up      PD vote: DCO slow, raise frequency
//   i_dn      PD vote: DCO fast, lower frequency
//   o_lambda  DCO tuning word (decode of o_idx)
//   o_e       DCO enable
//   o_idx     current tuning index
//   o_locked  lock indicator
//   o_state   FSM state for debug (0 IDLE, 1 SETTLE, 2 TRACK)
//
// Handshake: there is no valid/ready flow here; i_up/i_dn are sampled on every
// rising edge while in TRACK, and all outputs are registered.
// ---------------------------------------------------------------------------
module dco_tune_ctrl #(
    parameter int N_TUNE   = 10,
    parameter int INIT_IDX = 4,
    parameter int SETTLE   = 8,
    parameter int FILT     = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_up,
    input  logic              i_dn,
    output logic [N_TUNE-1:0] o_lambda,
    output logic              o_e,
    output logic [3:0]        o_idx,
    output logic              o_locked,
    output logic [1:0]        o_state
);

    localparam int IDX_W = 4;
    localparam int V_W   = $clog2(FILT + 1) + 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [V_W-1:0] V_POS = V_W'(FILT);
    localparam logic signed [V_W-1:0] V_NEG = V_W'(-FILT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_TRACK  = 2'd2
    } state_t;

    // Last step direction
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    function automatic logic [N_TUNE-1:0] f_decode(input logic [IDX_W-1:0] idx);
        logic [N_TUNE-1:0] d;
        d = '0;
        for (int i = 0; i < N_TUNE; i++) begin
`ifdef DCO_TUNE_CTRL_THERM_EN
            d[i] = (i <= int'(idx));
`else
            d[i] = (i == int'(idx));
`endif
        end
        return d;
    endfunction

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [N_TUNE-1:0]       r_lambda;
    logic                    r_e;
    logic                    r_locked;
    logic signed [V_W-1:0]   r_v;
    logic [SET_W-1:0]        r_settle;
    logic [LCK_W-1:0]        r_lock_cnt;
    logic [1:0]              r_last_dir;

    logic signed [V_W-1:0]   w_v_next;
    logic                    w_step_up;
    logic                    w_step_dn;
    logic [1:0]              w_dir;
    logic [IDX_W-1:0]        w_idx_next;

    // Vote filter and index step decision, evaluated from the current votes
    // so the step lands on the same edge that completes the count.
    always_comb begin
        w_v_next = r_v;
        if (i_up && !i_dn) begin
            w_v_next = r_v + V_W'(1);
        end else if (i_dn && !i_up) begin
            w_v_next = r_v - V_W'(1);
        end
        w_step_up  = (w_v_next == V_POS);
        w_step_dn  = (w_v_next == V_NEG);
        w_dir      = w_step_up ? DIR_UP : DIR_DN;
        w_idx_next = r_idx;
        if (w_step_up && r_idx != IDX_W'(N_TUNE - 1)) begin
            w_idx_next = r_idx + IDX_W'(1);
        end else if (w_step_dn && r_idx != '0) begin
            w_idx_next = r_idx - IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= IDX_W'(INIT_IDX);
            r_lambda   <= f_decode(IDX_W'(INIT_IDX));
            r_e        <= 1'b0;
            r_locked   <= 1'b0;
            r_v        <= '0;
            r_settle   <= '0;
            r_lock_cnt <= '0;
            r_last_dir <= DIR_NONE;
        end else if (r_state != S_IDLE && !i_en) begin
            // Disable wins over any step pending this cycle.
            r_state    <= S_IDLE;
            r_idx      <= IDX_W'(INIT_IDX);
            r_lambda   <= f_decode(IDX_W'(INIT_IDX));
            r_e        <= 1'b0;
            r_locked   <= 1'b0;
            r_v        <= '0;
            r_settle   <= '0;
            r_lock_cnt <= '0;
            r_last_dir <= DIR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_state  <= S_SETTLE;
                        r_e      <= 1'b1;
                        r_settle <= '0;
                    end
                end
                S_SETTLE: begin
                    // Votes ignored while the DCO settles.
                    if (r_settle == SET_W'(SETTLE - 1)) begin
                        r_state <= S_TRACK;
                        r_v     <= '0;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                S_TRACK: begin
                    if (w_step_up || w_step_dn) begin
                        // Saturated steps still clear v and count for lock.
                        r_idx      <= w_idx_next;
                        r_lambda   <= f_decode(w_idx_next);
                        r_v        <= '0;
                        r_last_dir <= w_dir;
                        if (r_last_dir == DIR_NONE) begin
                            r_lock_cnt <= r_lock_cnt;
                        end else if (r_last_dir != w_dir) begin
                            if (r_lock_cnt != LCK_W'(LOCK_CNT)) begin
                                r_lock_cnt <= r_lock_cnt + LCK_W'(1);
                            end
                            if (r_lock_cnt == LCK_W'(LOCK_CNT - 1)) begin
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_lock_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    end else begin
                        r_v <= w_v_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_lambda = r_lambda;
    assign o_e      = r_e;
    assign o_idx    = r_idx;
    assign o_locked = r_locked;
    assign o_state  = r_state;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
module tb_dco_tune_ctrl;

  localparam int N_TUNE   = 10;
  localparam int INIT_IDX = 4;
  localparam int SETTLE   = 8;
  localparam int FILT     = 2;
  localparam int LOCK_CNT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic up  = 1'b0;
  logic dn  = 1'b0;
  always #5 clk = ~clk;

  logic [N_TUNE-1:0] lambda;
  logic              e;
  logic [3:0]        idx;
  logic              locked;
  logic [1:0]        state;

  dco_tune_ctrl #(
    .N_TUNE(N_TUNE), .INIT_IDX(INIT_IDX), .SETTLE(SETTLE),
    .FILT(FILT), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_dn(dn),
    .o_lambda(lambda), .o_e(e), .o_idx(idx), .o_locked(locked),
    .o_state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural reference model
  bit m_active;
  int m_settle_left;
  int m_v;
  int m_idx;
  int m_hist[$];  // +1 / -1 per step since tracking began

  function automatic void m_clear();
    m_active      = 0;
    m_settle_left = 0;
    m_v           = 0;
    m_idx         = INIT_IDX;
    m_hist.delete();
  endfunction

  // Locked when the most recent steps contain at least LOCK_CNT direction
  // reversals in a row.
  function automatic bit m_locked();
    int alt = 0;
    for (int i = m_hist.size() - 1; i >= 1; i--) begin
      if (m_hist[i] != m_hist[i-1]) alt++;
      else break;
    end
    return alt >= LOCK_CNT;
  endfunction

  function automatic logic [N_TUNE-1:0] m_lambda();
`ifdef DCO_TUNE_CTRL_THERM_EN
    return N_TUNE'((1 << (m_idx + 1)) - 1);
`else
    return N_TUNE'(1 << m_idx);
`endif
  endfunction

  function automatic int m_phase();
    if (!m_active) return 0;
    if (m_settle_left > 0) return 1;
    return 2;
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_clear();
    end else if (!m_active) begin
      if (en) begin
        m_active      = 1;
        m_settle_left = SETTLE;
      end
    end else if (!en) begin
      m_clear();
    end else if (m_settle_left > 0) begin
      m_settle_left--;
      m_v = 0;
    end else begin
      m_v += (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
      if (m_v == FILT || m_v == -FILT) begin
        if (m_v > 0) m_idx = (m_idx < N_TUNE - 1) ? m_idx + 1 : m_idx;
        else         m_idx = (m_idx > 0) ? m_idx - 1 : 0;
        m_hist.push_back(m_v > 0 ? 1 : -1);
        if (m_hist.size() > 16) void'(m_hist.pop_front());
        m_v = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: model follows the inputs sampled at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    chk("idx",    32'(idx),    32'(m_idx));
    chk("lambda", 32'(lambda), 32'(m_lambda()));
    chk("e",      32'(e),      32'(m_active));
    chk("locked", 32'(locked), 32'(m_locked()));
    chk("state",  32'(state),  32'(m_phase()));
  endtask

  // driver: hold inputs for n cycles
  task automatic drive(input logic d_en, input logic d_up, input logic d_dn, input int n);
    en = d_en; up = d_up; dn = d_dn;
    repeat (n) tick();
  endtask

  initial begin
    m_clear();
    // reset
    rst = 1'b1;
    drive(0, 0, 0, 2);
    chk("rst_idx", 32'(idx), 32'(INIT_IDX));
    rst = 1'b0;

    // enable, up held through settle, ramp up to saturation
    drive(1, 1, 0, 1);
    chk("e_rise", 32'(e), 32'd1);
    drive(1, 1, 0, SETTLE);
    chk("settle_idx", 32'(idx), 32'(INIT_IDX));
    drive(1, 1, 0, 14);
    chk("sat_hi", 32'(idx), 32'(N_TUNE - 1));
    // ramp down to saturation at 0
    drive(1, 0, 1, 24);
    chk("sat_lo", 32'(idx), 32'd0);

    // restart and alternate +1,-1,+1,-1,+1 then repeat +1
    drive(0, 0, 0, 1);
    drive(1, 0, 0, SETTLE + 1);
    for (int k = 0; k < 5; k++) drive(1, (k % 2) == 0, (k % 2) == 1, 2);
    chk("lock_set", 32'(locked), 32'd1);
    drive(1, 1, 0, 2);
    chk("lock_clr", 32'(locked), 32'd0);

    // non-completing vote patterns
    for (int k = 0; k < 4; k++) drive(1, (k % 2) == 0, (k % 2) == 1, 1);
    drive(1, 1, 1, 10);

    // disable on the cycle a step would occur
    drive(0, 0, 0, 1);
    drive(1, 0, 0, SETTLE + 1);
    drive(1, 1, 0, 5);
    drive(0, 1, 0, 1);
    chk("dis_idx", 32'(idx), 32'(INIT_IDX));
    drive(1, 0, 0, SETTLE + 1);

    // reset while locked in TRACK
    for (int k = 0; k < 5; k++) drive(1, (k % 2) == 0, (k % 2) == 1, 2);
    drive(1, 1, 0, 1);
    rst = 1'b1;
    drive(1, 1, 0, 1);
    rst = 1'b0;

    // randomized traffic
    for (int b = 0; b < 40; b++) begin
      int bias = $urandom_range(0, 3);
      for (int c = 0; c < 20; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        en  = ($urandom_range(0, 59) != 0);
        case (bias)
          0: begin up = ($urandom_range(0, 3) != 0); dn = ($urandom_range(0, 3) == 0); end
          1: begin up = ($urandom_range(0, 3) == 0); dn = ($urandom_range(0, 3) != 0); end
          2: begin up = (c / 2) % 2 == 0; dn = (c / 2) % 2 == 1; end
          default: begin up = $urandom_range(0, 1); dn = $urandom_range(0, 1); end
        endcase
        tick();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
